accu_result_fifo: RTL and testbench
===================================

# accu_result_fifo

Result buffer sitting directly downstream of the 8-sample XOR accumulator. Captures each single-cycle result pulse (`valid_b`/`data_out`) the accumulator emits, and holds it in a small circular FIFO. Presents results to the consumer over a valid/ready handshake. The accumulator cannot be stalled, so this block absorbs consumer backpressure and flags any result lost to overflow.

## Interface
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.
- `WIDTH`, default 8: result width in bits; matches accumulator output.
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: one-cycle result strobe; connects to accumulator `valid_b`.
- `in_data`  in  WIDTH: result value; connects to accumulator `data_out`.
- `in_ready`  out  1: not full. Informational only, because upstream never stalls.
- `out_valid`  out  1: head entry available.
- `out_ready`  in  1: consumer accepts head this cycle.
- `out_data`  out  WIDTH: head entry value.
- `count`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow`  out  1: sticky flag, set when a result is dropped.
- `ovf_clr`  in  1: synchronous clear of `overflow`.

## Operation
- Push = `in_valid && (count < DEPTH || pop)`.
- Pop = `out_valid && out_ready`.
- Storage is an array of DEPTH entries, with write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits wide. Both pointers wrap modulo DEPTH naturally.
- On push: write `in_data` to `mem[wr_ptr]`, then `wr_ptr` increments.
- On pop: `rd_ptr` increments.
- `count` rules:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- `out_valid = (count != 0)`; `out_data = mem[rd_ptr]`; `in_ready = (count != DEPTH)`.
- Full with `in_valid` and no pop: the incoming value is discarded, the FIFO is unchanged, and `overflow` is set next cycle.
- Full with `in_valid` and pop in the same cycle: both occur, `count` stays at DEPTH, and there is no overflow.
- Empty with `in_valid`: no bypass. The entry becomes visible on the next cycle.
- `ovf_clr` and a drop in the same cycle: the set wins, so `overflow` stays 1.
- Ordering is strict FIFO; no entry is ever reordered or duplicated.

## Timing
- Reset values: `out_valid` 0, `count` 0, `overflow` 0, `in_ready` 1, all `mem` entries 0, so `out_data` reads 0. Pointers reset to 0.
- Reset asserted mid-operation empties the FIFO immediately (asynchronous). Contents are lost and no pop is reported.
- Latency: a push in cycle N gives `out_valid` = 1 and `out_data` = the pushed value in cycle N+1 when the FIFO was empty.
- Throughput: one push and one pop per cycle, sustained.
- `out_data` is stable while `out_valid && !out_ready`.
- `count` and `overflow` are registered outputs.
- `in_ready` and `out_valid` are decoded from registered `count`, with no combinational path from inputs.

## Configuration
- `ACCU_FIFO_PARITY_EN` defined:
  - Each entry stores WIDTH+1 bits; the extra bit is `^in_data`, computed at push.
  - Adds output port `out_parity` (1 bit), driven by the stored bit of the head entry and reset to 0.
  - Lets the consumer detect storage corruption.
- `ACCU_FIFO_PARITY_EN` not defined: no parity bit, no `out_parity` port; storage is WIDTH bits per entry.

## Structure
- Shared package `accu_pkg` holds:
  - `ACCU_DATA_W` = 8, shared with the accumulator.
  - `ACCU_FIFO_DEPTH` = 4.
  - `accu_data_t` (logic [ACCU_DATA_W-1:0]).
- One sub-module, `accu_fifo_mem`: DEPTH×entry register array with a synchronous write port and an asynchronous read port, reset to zero. The pointer, count and flag logic stays in the top level.

## Test plan
- Reset check: assert `rst` → `out_valid` 0, `count` 0, `overflow` 0, `in_ready` 1, `out_data` 8'h00.
- Single pass: push 8'hA5 with `out_ready` 0 → next cycle `out_valid` 1, `out_data` A5, `count` 1. Raise `out_ready` → following cycle `count` 0, `out_valid` 0.
- Fill and overflow: with `out_ready` 0, push 01, 02, 03, 04 → `count` 4, `in_ready` 0. Push 05 → dropped, `overflow` 1. Drain → reads 01, 02, 03, 04 in order. Pulse `ovf_clr` → `overflow` 0.
- Full with simultaneous push/pop: full of 10..13, push 14 with `out_ready` 1 → 10 popped, `count` stays 4, `overflow` 0. Drain → 11, 12, 13, 14.
- Pointer wrap: push/pop continuously for 10 results (values 0x20..0x29) with `out_ready` 1 → every value emerges one cycle after push, in order. `count` never exceeds 1.
- Reset mid-stream: hold 3 entries, assert `rst` for 1 cycle → `count` 0 immediately. The next push of 8'h7E is the first value out.

Source files
------------

// File: rtl/accu_pkg.sv
// Shared definitions for the XOR accumulator and its result FIFO.
package accu_pkg;

  localparam int ACCU_DATA_W     = 8;
  localparam int ACCU_FIFO_DEPTH = 4;

  typedef logic [ACCU_DATA_W-1:0] accu_data_t;

endpackage

// File: rtl/accu_fifo_mem.sv
// DEPTH x ENTRY_W register array: synchronous write port, asynchronous read port,
// cleared to zero on reset.
module accu_fifo_mem #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  // NOTE: the array is reset because the head must read 0 out of reset; a RAM macro could not do this.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/accu_result_fifo.sv
// Result buffer behind the 8-sample XOR accumulator: circular FIFO with sticky overflow.
// Define ACCU_FIFO_PARITY_EN to store a parity bit per entry and expose out_parity.
module accu_result_fifo
  import accu_pkg::*;
#(
  parameter int DEPTH  = ACCU_FIFO_DEPTH,
  parameter int WIDTH  = ACCU_DATA_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             overflow,
  input  logic             ovf_clr
`ifdef ACCU_FIFO_PARITY_EN
  ,
  output logic             out_parity
`endif
);

`ifdef ACCU_FIFO_PARITY_EN
  localparam int ENTRY_W = WIDTH + 1;
`else
  localparam int ENTRY_W = WIDTH;
`endif

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               full, push, pop, drop;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign in_ready  = !full;
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A drop outranks a simultaneous clear so no loss goes unreported.
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef ACCU_FIFO_PARITY_EN
  assign wr_entry   = {^in_data, in_data};
  assign out_parity = rd_entry[WIDTH];
`else
  assign wr_entry   = in_data;
`endif

  accu_fifo_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_entry)
  );

  assign out_data = rd_entry[WIDTH-1:0];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_accu_result_fifo.sv
// Directed self-checking bench for accu_result_fifo (default build, DEPTH 4, WIDTH 8).
module tb_accu_result_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       overflow;
  logic       ovf_clr;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  accu_result_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_count",     count,     0);
    check("rst_overflow",  overflow,  0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_data",  out_data,  8'h00);
    tick();
    rst = 1'b0;
    tick();

    // Single pass
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    check("single_out_valid", out_valid, 1);
    check("single_out_data",  out_data,  8'hA5);
    check("single_count",     count,     1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_drain_count", count,     0);
    check("single_drain_valid", out_valid, 0);

    // Fill and overflow
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
    end
    check("fill_count",    count,    4);
    check("fill_in_ready", in_ready, 0);
    check("fill_no_ovf",   overflow, 0);
    in_data = 8'h05;
    tick();
    in_valid = 1'b0;
    check("drop_overflow", overflow, 1);
    check("drop_count",    count,    4);
    check("drop_head",     out_data, 8'h01);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_%0d", i), out_data, 8'(i));
      tick();
    end
    out_ready = 1'b0;
    check("drain_count",    count,    0);
    check("drain_ovf_held", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'h10 + 8'(i);
      tick();
    end
    check("pp_full_count", count,    4);
    check("pp_head",       out_data, 8'h10);
    in_data = 8'h14; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pp_count",    count,    4);
    check("pp_no_ovf",   overflow, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pp_drain_%0d", i), out_data, 8'h11 + 8'(i));
      tick();
    end
    check("pp_empty", count, 0);

    // Streaming through the pointer wrap
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'h20 + 8'(i);
      tick();
      check($sformatf("wrap_valid_%0d", i), out_valid, 1);
      check($sformatf("wrap_data_%0d", i),  out_data,  8'h20 + 8'(i));
      check($sformatf("wrap_count_%0d", i), count,     1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("wrap_empty", count, 0);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h30 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    check("mid_count", count, 3);
    rst = 1'b1;
    #1;
    check("mid_rst_count", count,     0);
    check("mid_rst_valid", out_valid, 0);
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h7E;
    tick();
    in_valid = 1'b0;
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data",  out_data,  8'h7E);
    check("post_rst_count", count,     1);

    // Drop coinciding with ovf_clr: the set wins
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h40 + 8'(i);
      tick();
    end
    check("clr_full", count, 4);
    in_data = 8'h99; ovf_clr = 1'b1;
    tick();
    in_valid = 1'b0; ovf_clr = 1'b0;
    check("clr_vs_drop_ovf", overflow, 1);
    check("clr_vs_drop_head", out_data, 8'h7E);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
